// File: rtl/axis_arb_pkg.sv
// axis_arb_pkg: shared state type and index-width helper for packet arbiters
package axis_arb_pkg;

    typedef enum logic {IDLE, BUSY} arb_state_t;

    function automatic int src_idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// rr_priority_pick: combinational round-robin pick of the first request at or after ptr
module rr_priority_pick
    import axis_arb_pkg::*;
#(
    parameter int N = 4,
    parameter int W = src_idx_width(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         any_req,
    output logic [W-1:0] idx
);

    logic [W-1:0] cand;

    // scan offsets from farthest to nearest so the request closest to ptr wins
    always_comb begin
        any_req = |req;
        idx = '0;
        cand = '0;
        for (int k = N - 1; k >= 0; k--) begin
            cand = W'((int'(ptr) + k) % N);
            if (req[cand]) idx = cand;
        end
    end

endmodule

// File: rtl/axis_packet_arbiter.sv
// axis_packet_arbiter: packet-granular round-robin merge of AXI4-Stream sources; AXIS_ARB_SRC_ID_EN adds out_src
module axis_packet_arbiter
    import axis_arb_pkg::*;
#(
    parameter int NUM_INPUTS = 4,
    parameter int AXI_WIDTH  = 512
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_INPUTS*AXI_WIDTH-1:0]   in_tdata,
    input  logic [NUM_INPUTS*AXI_WIDTH/8-1:0] in_tkeep,
    input  logic [NUM_INPUTS-1:0]             in_tlast,
    input  logic [NUM_INPUTS-1:0]             in_tvalid,
    output logic [NUM_INPUTS-1:0]             in_tready,
    output logic [AXI_WIDTH-1:0]              out_tdata,
    output logic [AXI_WIDTH/8-1:0]            out_tkeep,
    output logic                              out_tlast,
    output logic                              out_tvalid,
`ifdef AXIS_ARB_SRC_ID_EN
    output logic [src_idx_width(NUM_INPUTS)-1:0] out_src,
`endif
    input  logic                              out_tready
);

    localparam int W  = src_idx_width(NUM_INPUTS);
    localparam int KW = AXI_WIDTH / 8;

    arb_state_t   state, state_n;
    logic [W-1:0] g, g_n, p, p_n, pick, g_inc;
    logic         any_req, busy, fire_last;

    rr_priority_pick #(.N(NUM_INPUTS), .W(W)) u_pick (
        .req     (in_tvalid),
        .ptr     (p),
        .any_req (any_req),
        .idx     (pick)
    );

    assign busy      = (state == BUSY);
    assign fire_last = out_tvalid && out_tready && out_tlast;
    assign g_inc     = (g == W'(NUM_INPUTS - 1)) ? '0 : g + 1'b1;

`ifdef AXIS_ARB_SRC_ID_EN
    assign out_src = busy ? g : '0;
`endif

    // state, grant and priority pointer registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            g     <= '0;
            p     <= '0;
        end else begin
            state <= state_n;
            g     <= g_n;
            p     <= p_n;
        end
    end

    // arbitrate only in IDLE; hold the grant until the tlast handshake
    always_comb begin
        state_n = state;
        g_n = g;
        p_n = p;
        if (state == IDLE && any_req) begin
            state_n = BUSY;
            g_n = pick;
        end else if (state == BUSY && fire_last) begin
            state_n = IDLE;
            p_n = g_inc;
        end
    end

    // pass the granted input straight through while busy; everything low when idle
    always_comb begin
        out_tdata = '0;
        out_tkeep = '0;
        out_tlast = 1'b0;
        out_tvalid = 1'b0;
        in_tready = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (busy && g == W'(i)) begin
                out_tdata = in_tdata[i*AXI_WIDTH +: AXI_WIDTH];
                out_tkeep = in_tkeep[i*KW +: KW];
                out_tlast = in_tlast[i];
                out_tvalid = in_tvalid[i];
                in_tready[i] = out_tready;
            end
        end
    end

endmodule

// File: doc/axis_packet_arbiter.md
# axis_packet_arbiter

Merges NUM_INPUTS AXI4-Stream sources onto one AXI4-Stream sink at packet granularity, so beats of different packets never interleave. Grants are round-robin: once a packet finishes, the input after the last winner gets first priority. Sits upstream of the AXI-to-ndata/data adapters when several producers share one datapath lane.

## Interface
- NUM_INPUTS, 4: number of requesting streams, ≥1.
- AXI_WIDTH, 512: tdata width in bits, multiple of 8.
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-low.
- in_tdata  in  NUM_INPUTS*AXI_WIDTH  input i occupies bits [i*AXI_WIDTH +: AXI_WIDTH].
- in_tkeep  in  NUM_INPUTS*AXI_WIDTH/8  per-input byte keep, same packing.
- in_tlast  in  NUM_INPUTS  per-input end of packet.
- in_tvalid  in  NUM_INPUTS  per-input valid.
- in_tready  out  NUM_INPUTS  per-input ready.
- out_tdata  out  AXI_WIDTH  merged data.
- out_tkeep  out  AXI_WIDTH/8  merged keep.
- out_tlast  out  1  merged last.
- out_tvalid  out  1  merged valid.
- out_tready  in  1  sink ready.
- out_src  out  max(1,$clog2(NUM_INPUTS))  index of the granted input; present only with AXIS_ARB_SRC_ID_EN.

## Operation
- Two states:
  - IDLE: no grant.
  - BUSY: one input holds the grant.
- Registers:
  - state.
  - grant index g.
  - round-robin pointer p, the highest-priority input.
- IDLE:
  - out_tvalid=0 and all in_tready=0.
  - If any in_tvalid is high, pick the first valid index scanning p, p+1, … modulo NUM_INPUTS.
  - Register the pick as g and go to BUSY.
- BUSY, combinational pass-through from input g:
  - out_tdata, out_tkeep, out_tlast and out_tvalid come from input g.
  - in_tready[g]=out_tready; all other in_tready are 0.
- Packet end: when out_tvalid && out_tready && out_tlast, set p ← (g+1) mod NUM_INPUTS and return to IDLE.
- A beat with tlast=0 never releases the grant, whatever its length.
- The grant is not revoked if in_tvalid[g] drops mid-packet. The output simply stalls with out_tvalid=0.
- Requests that arrive while BUSY wait. They do not change g or p.
- NUM_INPUTS=1: the block degenerates to pass-through with one idle cycle between packets. p stays 0.

## Timing
- Reset:
  - state=IDLE, g=0, p=0.
  - out_tvalid=0, all in_tready=0, out_tlast=0.
  - out_tdata, out_tkeep and out_src=0.
- Reset mid-packet drops the grant immediately. The partial packet is not terminated; upstream must reset too.
- Arbitration latency: a request seen in IDLE in cycle N gives a first possible output beat in cycle N+1.
- Inter-packet gap: exactly one IDLE cycle after each tlast handshake.
- Throughput within a packet is one beat per cycle; there are no added registers in the data path.
- out_tvalid is never asserted in the same cycle the arbiter samples requests.
- AXI rule preserved: once out_tvalid is high, data stays stable until ready, provided the granted source obeys AXI.

## Configuration
- AXIS_ARB_SRC_ID_EN defined:
  - out_src port exists and equals g while BUSY.
  - out_src is 0 in IDLE and at reset.
  - Consumers use it as a tdest/tid substitute.
- AXIS_ARB_SRC_ID_EN undefined: port and logic are absent; everything else is identical.

## Structure
- Shared package axis_arb_pkg holds:
  - typedef arb_state_t {IDLE, BUSY}.
  - function src_idx_width(n) returning max(1,$clog2(n)).
- Sub-module rr_priority_pick, purely combinational:
  - Inputs: request vector and pointer p.
  - Outputs: any_req and the winning index.
  - Reused by future schedulers.
- Top level holds the FSM, the g/p registers and the output mux.

## Test plan
- Reset, then assert in_tvalid[2] with a 3-beat packet and out_tready=1:
  - first output beat one cycle after the request.
  - out_src=2.
  - p becomes 3 after the last beat.
- All four inputs request continuously with 2-beat packets:
  - grant order starting from p=0 is 0,1,2,3,0.
  - each packet's beats are contiguous.
  - one IDLE cycle between packets.
- Input 1 holds a 5-beat packet with in_tvalid dropping in beat 3 for 2 cycles while input 0 requests:
  - output stalls.
  - no beat from input 0 appears until input 1's tlast.
- out_tready toggles 1,0,1,0 during a 4-beat packet: each beat appears once, data stable while ready is 0, in_tready[g] mirrors out_tready.
- rst_n asserted for 1 cycle in the 2nd beat of a packet:
  - next cycle out_tvalid=0, all in_tready=0.
  - p=0, so after reset input 0 wins over input 3 when both request.
